// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit add/subtract split into SEGMENTS carry-chained slices, one slice per stage.
// Latency SEGMENTS cycles at 1 beat/cycle; global stall: all stages hold while out_valid && !out_ready.
// Define PIPE_ADDSUB_OVF_EN to add out_ovf (signed overflow), which travels with its beat.
module pipe_addsub #(
    parameter int WIDTH    = 32,
    parameter int SEGMENTS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
`ifdef PIPE_ADDSUB_OVF_EN
    output logic             out_ovf,
`endif
    output logic             out_cout
);

    localparam int SW   = WIDTH / SEGMENTS;
    localparam int LAST = SEGMENTS - 1;

    generate
        if (SEGMENTS < 1 || (WIDTH % SEGMENTS) != 0) begin : g_bad_cfg
            $error("pipe_addsub: WIDTH must be a positive multiple of SEGMENTS");
        end
    endgenerate

    logic                adv;
    logic [SEGMENTS-1:0] vld_q;
    logic [SEGMENTS-1:0] c_q;
    logic [WIDTH-1:0]    a_q [SEGMENTS];
    logic [WIDTH-1:0]    b_q [SEGMENTS];
    logic [WIDTH-1:0]    s_q [SEGMENTS];

    // Per-stage inputs (previous stage registers, or the conditioned operands for stage 0)
    logic [SEGMENTS-1:0] v_p;
    logic [SEGMENTS-1:0] c_p;
    logic [SEGMENTS-1:0] c_d;
    logic [WIDTH-1:0]    a_p [SEGMENTS];
    logic [WIDTH-1:0]    b_p [SEGMENTS];
    logic [WIDTH-1:0]    s_p [SEGMENTS];
    logic [WIDTH-1:0]    s_d [SEGMENTS];
    logic [SW:0]         slice [SEGMENTS];

    assign adv      = !vld_q[LAST] || out_ready;
    assign in_ready = adv;

    always_comb begin
        v_p[0] = in_valid;
        a_p[0] = in_a;
        b_p[0] = in_sub ? ~in_b : in_b;
        c_p[0] = in_sub ? ~in_cin : in_cin;
        s_p[0] = '0;
        for (int k = 1; k < SEGMENTS; k++) begin
            v_p[k] = vld_q[k-1];
            a_p[k] = a_q[k-1];
            b_p[k] = b_q[k-1];
            c_p[k] = c_q[k-1];
            s_p[k] = s_q[k-1];
        end
        for (int k = 0; k < SEGMENTS; k++) begin
            slice[k] = {1'b0, a_p[k][k*SW +: SW]} + {1'b0, b_p[k][k*SW +: SW]}
                     + {{SW{1'b0}}, c_p[k]};
            s_d[k]             = s_p[k];
            s_d[k][k*SW +: SW] = slice[k][SW-1:0];
            c_d[k]             = slice[k][SW];
        end
    end

    // Flush clears only the valid bits; data lanes may keep stale values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            for (int k = 0; k < SEGMENTS; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            if (flush) begin
                vld_q <= '0;
            end else if (adv) begin
                vld_q <= v_p;
            end
            if (adv) begin
                c_q <= c_d;
                for (int k = 0; k < SEGMENTS; k++) begin
                    a_q[k] <= a_p[k];
                    b_q[k] <= b_p[k];
                    s_q[k] <= s_d[k];
                end
            end
        end
    end

    assign out_valid = vld_q[LAST];
    assign out_sum   = s_q[LAST];
    assign out_cout  = c_q[LAST];

`ifdef PIPE_ADDSUB_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Carry into the MSB recovered as a ^ b ^ sum at that bit.
    assign ovf_d = c_d[LAST] ^ (a_p[LAST][WIDTH-1] ^ b_p[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_addsub.sv
// Randomised and directed bench for pipe_addsub (WIDTH=8, SEGMENTS=2) against an arithmetic reference queue.
module tb_pipe_addsub;

    localparam int W   = 8;
    localparam int SEG = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef PIPE_ADDSUB_OVF_EN
    logic         out_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    exp_t         exp_q [$];
    logic [W-1:0] got_q [$];
    vec_t         dir   [5];

    pipe_addsub #(.WIDTH(W), .SEGMENTS(SEG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
`ifdef PIPE_ADDSUB_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .out_cout  (out_cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t e;
        int ua = int'(a);
        int ub = int'(b);
        int c  = int'(cin);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int r;
        int sr;
        if (sub) begin
            r    = ua - ub - c;
            sr   = sa - sb - c;
            e.co = (r >= 0);
        end else begin
            r    = ua + ub + c;
            sr   = sa + sb + c;
            e.co = (r > (2**W) - 1);
        end
        e.s  = W'(r);
        e.ov = (sr > (2**(W-1)) - 1) || (sr < -(2**(W-1)));
        return e;
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        logic acc = 1'b0;
        int   guard = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            guard++;
        end while (!acc && guard < 50);
        #1 in_valid = 1'b0;
        check("send_acc", acc, 1);
    endtask

    task automatic wait_out(input int lat, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 4*lat + 8);
        check(tag, n, lat);
    endtask

    task automatic rand_stream(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_cin    = 1'($urandom);
            in_sub    = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(31) == 0);
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
    endtask

    // Monitor: scoreboard, stall stability and in_ready rule, sampled on the falling edge.
    initial begin
        exp_t         e;
        logic         stall_prev;
        logic [W-1:0] sum_prev;
        logic         co_prev;
        stall_prev = 1'b0;
        sum_prev   = '0;
        co_prev    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                stall_prev = 1'b0;
            end else begin
                check("in_ready", in_ready, !out_valid || out_ready);
                if (stall_prev) begin
                    check("hold_vld", out_valid, 1);
                    check("hold_sum", out_sum, sum_prev);
                    check("hold_cout", out_cout, co_prev);
                end
                if (out_valid && out_ready) begin
                    check("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("sum", out_sum, e.s);
                        check("cout", out_cout, e.co);
`ifdef PIPE_ADDSUB_OVF_EN
                        check("ovf", out_ovf, e.ov);
`endif
                    end
                    got_q.push_back(out_sum);
                end
                if (flush) begin
                    exp_q.delete();
                end else if (in_valid && in_ready) begin
                    exp_q.push_back(model(in_a, in_b, in_cin, in_sub));
                end
                stall_prev = out_valid && !out_ready && !flush;
                sum_prev   = out_sum;
                co_prev    = out_cout;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        dir[0] = '{8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0};
        dir[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        dir[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        dir[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        dir[4] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", out_valid, 0);
        check("rst_sum", out_sum, 0);
        check("rst_cout", out_cout, 0);
`ifdef PIPE_ADDSUB_OVF_EN
        check("rst_ovf", out_ovf, 0);
`endif
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_rdy", in_ready, 1);
        @(posedge clk); #1;

        // Directed vectors: latency and result
        for (int i = 0; i < 5; i++) begin
            send(dir[i].a, dir[i].b, dir[i].cin, dir[i].sub);
            wait_out(SEG, "dir_lat");
            check("dir_sum", out_sum, dir[i].s);
            check("dir_cout", out_cout, dir[i].co);
`ifdef PIPE_ADDSUB_OVF_EN
            check("dir_ovf", out_ovf, dir[i].ov);
`endif
            @(posedge clk); #1;
        end

        // Backpressure: six back-to-back beats, output stalled 4 cycles at first out_valid
        got_q.delete();
        fork
            begin
                int   idx = 1;
                int   g2  = 0;
                logic acc2;
                while (idx <= 6 && g2 < 100) begin
                    in_valid = 1'b1; in_a = W'(idx); in_b = W'(idx); in_cin = 1'b0; in_sub = 1'b0;
                    @(negedge clk);
                    acc2 = in_ready;
                    @(posedge clk); #1;
                    if (acc2) idx++;
                    g2++;
                end
                in_valid = 1'b0;
            end
            begin
                int g = 0;
                do begin
                    @(posedge clk); #1;
                    g++;
                end while (!out_valid && g < 20);
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("bp_rdy", in_ready, 0);
                    check("bp_hold", out_sum, 8'h02);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (SEG + 8) begin
            @(posedge clk); #1;
        end
        check("bp_count", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            check("bp_order", got_q[i], 2 * (i + 1));
        end

        // Flush with one beat in stage 1 and another presented in the flush cycle
        send(8'h11, 8'h22, 1'b0, 1'b0);
        in_valid = 1'b1; in_a = 8'h33; in_b = 8'h44; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (SEG + 2) begin
            @(negedge clk);
            check("flush_vld", out_valid, 0);
            @(posedge clk); #1;
        end
        send(8'h40, 8'h02, 1'b0, 1'b1);
        wait_out(SEG, "flush_lat");
        check("flush_sum", out_sum, 8'h3E);
        check("flush_cout", out_cout, 1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a random stream
        rand_stream(60);
        #1 rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #1;
        check("mrst_vld", out_valid, 0);
        check("mrst_sum", out_sum, 0);
        check("mrst_cout", out_cout, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        send(8'h21, 8'h12, 1'b1, 1'b0);
        wait_out(SEG, "mrst_lat");
        check("mrst_res", out_sum, 8'h34);
        @(posedge clk); #1;

        // Long random run with random stalls and occasional flushes, then drain
        rand_stream(600);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (SEG + 4) begin
            @(posedge clk); #1;
        end
        check("drain_empty", exp_q.size(), 0);
        check("drain_vld", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
